// File: rtl/popcount_pkg.sv
// Shared widths, FSM encoding and saturating add for the pipelined popcount accumulator.
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int acc_width(input int n, input int max_beats);
    return $clog2(n * max_beats + 1);
  endfunction

  // Clamps a + b to 2^w - 1 (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] max_v;
    s     = {1'b0, a} + {1'b0, b};
    max_v = (33'd1 << w) - 33'd1;
    return (s > max_v) ? max_v[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/popcount_accum_pipe_group.sv
// Exact combinational popcount over one GROUP-bit slice; drop-in point for approximate variants.
module popcount_group #(
  parameter int GROUP = 6,
  parameter int CW    = $clog2(GROUP + 1)
) (
  input  logic [GROUP-1:0] bits,
  output logic [CW-1:0]    count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < GROUP; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/popcount_accum_pipe.sv
// Two-stage pipelined popcount with frame accumulation, optional LSB truncation,
// threshold fire bit and overflow flag.
module popcount_accum_pipe
  import popcount_pkg::*;
#(
  parameter int N         = 18,
  parameter int GROUP     = 6,
  parameter int MAX_BEATS = 8,
  parameter int TRUNC     = 1,
  parameter int CNT_W     = cnt_width(N),
  parameter int ACC_W     = acc_width(N, MAX_BEATS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  input  logic             approx_en,
  input  logic [ACC_W-1:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_fire,
  output logic             out_ovf,
  output state_t           dbg_state
);

  localparam int NG   = N / GROUP;
  localparam int PW   = $clog2(GROUP + 1);
  localparam int BC_W = $clog2(MAX_BEATS + 2);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // in_ready depends only on state (never on in_valid), out_valid only on state.
  state_t state_q, state_d;
  logic   drain_cnt_q;
  logic   accept, drain_exit, hold_exit;

  assign accept    = in_valid && in_ready;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      drain_cnt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= (state_q == DRAIN) ? ~drain_cnt_q : 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_last ? DRAIN : ACCUM;
      ACCUM:   if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (drain_cnt_q) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    drain_exit = 1'b0;
    hold_exit  = 1'b0;
    case (state_q)
      IDLE, ACCUM: in_ready = rst_n;
      DRAIN:       drain_exit = drain_cnt_q;
      HOLD: begin
        out_valid = 1'b1;
        hold_exit = out_ready;
      end
      default: ;
    endcase
  end

  // Stage 1: per-group exact partial counts.
  logic [PW-1:0] part_d [NG];
  logic [PW-1:0] part_q [NG];
  logic          s1_valid_q;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    popcount_group #(.GROUP(GROUP), .CW(PW)) u_grp (
      .bits  (in_data[g*GROUP +: GROUP]),
      .count (part_d[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      for (int i = 0; i < NG; i++) part_q[i] <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        for (int i = 0; i < NG; i++) part_q[i] <= part_d[i];
      end
    end
  end

  // Stage 2: beat total, optional truncation, saturating accumulate.
  logic [CNT_W-1:0] beat_sum, beat_eff;
  logic [ACC_W:0]   acc_wide;
  logic [ACC_W-1:0] acc_q, acc_sum;
  logic [ACC_W-1:0] thresh_q;
  logic [BC_W-1:0]  bcnt_q;
  logic             approx_q, sat_q;

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < NG; i++) begin
      beat_sum = beat_sum + CNT_W'(part_q[i]);
    end
  end

  assign beat_eff = approx_q ? ((beat_sum >> TRUNC) << TRUNC) : beat_sum;
  assign acc_wide = {1'b0, acc_q} + (ACC_W+1)'(beat_eff);
  assign acc_sum  = ACC_W'(sat_add(32'(acc_q), 32'(beat_eff), unsigned'(ACC_W)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      sat_q    <= 1'b0;
      bcnt_q   <= '0;
      approx_q <= 1'b0;
      thresh_q <= '0;
    end else begin
      if (hold_exit) begin
        acc_q  <= '0;
        sat_q  <= 1'b0;
        bcnt_q <= '0;
      end else begin
        if (s1_valid_q) begin
          acc_q <= acc_sum;
          if (acc_wide[ACC_W]) sat_q <= 1'b1;
        end
        if (accept && bcnt_q != BC_W'(MAX_BEATS + 1)) bcnt_q <= bcnt_q + 1'b1;
      end
      if (state_q == IDLE && accept) begin
        approx_q <= approx_en;
        thresh_q <= thresh;
      end
    end
  end

  // Results capture the fully drained accumulator and hold through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= '0;
      out_fire  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (drain_exit) begin
      out_count <= acc_q;
      out_fire  <= (acc_q >= thresh_q);
      out_ovf   <= (bcnt_q > BC_W'(MAX_BEATS)) || sat_q;
    end
  end

endmodule
